seed_reuse_checker: RTL

// - Front-end for the seed vector RAM (seed_vector_init). Accepts seed-use requests from the crypto

---
 rtl/seed_reuse_checker_pkg.sv | 22 ++
 rtl/seed_reuse_checker_if.sv | 23 ++
 rtl/seed_reuse_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/seed_reuse_checker_pkg.sv
// Shared constants for the seed reuse checker: bitmap RAM geometry and FSM encodings.
// The RAM geometry mirrors the seed_vector_init build of the bitmap.
package seed_reuse_checker_pkg;

    localparam int SEED_RAM_DW     = 32;
    localparam int SEED_RAM_DW_BIT = 5;
    localparam int SEED_RAM_AW     = 9;
    localparam int SEED_ADDR_W     = 32;
    localparam int REUSE_CNT_W     = 16;

    localparam logic [2:0] SRC_IDLE      = 3'd0;
    localparam logic [2:0] SRC_RD        = 3'd1;
    localparam logic [2:0] SRC_TEST      = 3'd2;
    localparam logic [2:0] SRC_RESP      = 3'd3;
    localparam logic [2:0] SRC_WAIT_INIT = 3'd4;

    // The RAM is enabled only while the checker owns an address: the read and the test/write cycles.
    function automatic logic is_ram_state(input logic [2:0] state);
        return (state == SRC_RD) || (state == SRC_TEST);
    endfunction

endpackage

// File: rtl/seed_reuse_checker_if.sv
// Request/response handshake between the seed generator (master) and the reuse checker (slave).
interface seed_reuse_checker_if;
    import seed_reuse_checker_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [SEED_ADDR_W-1:0] req_addr;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_fresh;
    logic [SEED_ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_fresh, rsp_addr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_fresh, rsp_addr
    );

endinterface

// File: rtl/seed_reuse_checker.sv
// Read-test-set front end for the seed bitmap RAM: marks fresh seeds and counts reused ones.
// A clear sequence from seed_vector_init pre-empts any in-flight check, which is then replayed.
module seed_reuse_checker
    import seed_reuse_checker_pkg::*;
#(
    parameter int DW     = SEED_RAM_DW,
    parameter int DW_BIT = SEED_RAM_DW_BIT,
    parameter int CNT_W  = REUSE_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    seed_reuse_checker_if.slave    bus,
    output logic [SEED_ADDR_W-1:0] ram_addr,
    output logic                   ram_ce,
    output logic                   ram_we,
    input  logic [DW-1:0]          ram_rdata,
    input  logic                   init_busy,
    output logic [CNT_W-1:0]       reuse_cnt
);

    logic [2:0]             state_r;
    logic [2:0]             next_s;
    logic [SEED_ADDR_W-1:0] addr_r;
    logic                   fresh_r;
    logic                   rsp_valid_r;
    logic                   ram_ce_r;
    logic [CNT_W-1:0]       reuse_cnt_r;
    logic                   accept_s;
    logic                   seed_bit_s;
    logic                   test_done_s;
    logic                   cnt_full_s;

    assign accept_s    = (state_r == SRC_IDLE) && bus.req_valid && !init_busy;
    assign seed_bit_s  = ram_rdata[addr_r[DW_BIT-1:0]];
    assign test_done_s = (state_r == SRC_TEST) && !init_busy;
    assign cnt_full_s  = (reuse_cnt_r == {CNT_W{1'b1}});

    // Next-state decode of the read-test-set sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            SRC_IDLE: begin
                if (accept_s) next_s = SRC_RD;
                else          next_s = SRC_IDLE;
            end
            SRC_RD: begin
                if (init_busy) next_s = SRC_WAIT_INIT;
                else           next_s = SRC_TEST;
            end
            SRC_TEST: begin
                if (init_busy) next_s = SRC_WAIT_INIT;
                else           next_s = SRC_RESP;
            end
            SRC_RESP: begin
                if (bus.rsp_ready) next_s = SRC_IDLE;
                else               next_s = SRC_RESP;
            end
            SRC_WAIT_INIT: begin
                if (init_busy) next_s = SRC_WAIT_INIT;
                else           next_s = SRC_RD;
            end
            default: next_s = SRC_IDLE;
        endcase
    end

    // State register plus the registered RAM enable and response-valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SRC_IDLE;
            ram_ce_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            ram_ce_r    <= is_ram_state(next_s);
            rsp_valid_r <= (next_s == SRC_RESP);
        end
    end

    // Captured seed address and the fresh/reuse verdict of the test cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {SEED_ADDR_W{1'b0}};
            fresh_r <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r <= bus.req_addr;
            end
            if (test_done_s) begin
                fresh_r <= !seed_bit_s;
            end
        end
    end

    // Saturating reuse counter; the explicit hold keeps the register well-defined every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_cnt_r <= {CNT_W{1'b0}};
        end else if (test_done_s && seed_bit_s && !cnt_full_s) begin
            reuse_cnt_r <= reuse_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            reuse_cnt_r <= reuse_cnt_r;
        end
    end

    // The write must land in the same cycle the read data is tested, so it stays combinational;
    // gating with rst keeps a reset in TEST from marking the seed.
    assign ram_we        = test_done_s && !seed_bit_s && !rst;
    assign ram_ce        = ram_ce_r;
    assign ram_addr      = addr_r;
    assign bus.req_ready = (state_r == SRC_IDLE) && !init_busy && !rst;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_fresh = fresh_r;
    assign bus.rsp_addr  = addr_r;
    assign reuse_cnt     = reuse_cnt_r;

endmodule
